wb_burst_master: RTL and testbench

//   Wishbone B4 pipelined bus initiator. It is the master-side counterpart to the
//   SoC's Wishbone slave peripherals (timer, GPIO, RAM).
//   - Accepts one burst command at a time: direction, start address, beat count.
//   - Issues sequential single-word pipelined transfers and streams data in
//     (writes) or out (reads).
//   - Reports completion with an OK / bus-error / timeout status.

---
 rtl/wb_burst_master.sv | 157 +++++++++++++++
 tb/tb_wb_burst_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// Wishbone B4 pipelined burst initiator: one command at a time, sequential
// single-word beats, bounded outstanding count, OK / bus-error / timeout status.
module wb_burst_master #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [DW-1:0]   wdata,
  input  logic            wdata_valid,
  output logic            wdata_ready,
  output logic [DW-1:0]   rdata,
  output logic            rdata_valid,
  output logic            done,
  output logic [1:0]      status,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_stall_i
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = LEN_W + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 2);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FINISH} state_t;

  state_t           state;
  logic             we_q;
  logic [LEN_W-1:0] len_q;
  logic [AW-1:0]    next_adr;
  logic [CW-1:0]    issued, acked, beats;
  logic [OW-1:0]    outst, outst_next;
  logic [TW-1:0]    tmo;
  logic active, pending, accepted, slot_open;
  logic ack_hit, err_hit, tmo_hit, abort, last_ack, can_issue;

  assign wb_sel_o = '1;

  always_comb begin
    active     = (state == S_ACTIVE);
    pending    = (outst != '0);
    accepted   = wb_stb_o & ~wb_stall_i;
    slot_open  = ~wb_stb_o | ~wb_stall_i;
    err_hit    = active & pending & wb_err_i;
    ack_hit    = active & pending & wb_ack_i & ~wb_err_i;
    // an ack in the final allowed cycle still counts as in time
    tmo_hit    = active & pending & ~ack_hit & (tmo == TW'(TIMEOUT - 1));
    abort      = err_hit | tmo_hit;
    beats      = CW'(len_q) + CW'(1);
    last_ack   = ack_hit & (acked == CW'(len_q));
    // a beat loaded now is accepted no earlier than next edge, so budget against
    // the count as it will stand after this edge
    outst_next = outst + OW'(accepted) - OW'(ack_hit);
    can_issue  = active & ~abort & slot_open & (issued < beats) &
                 (outst_next < OW'(MAX_OUTST)) & (~we_q | wdata_valid);
    wdata_ready = can_issue & we_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      we_q        <= 1'b0;
      len_q       <= '0;
      next_adr    <= '0;
      issued      <= '0;
      acked       <= '0;
      outst       <= '0;
      tmo         <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      status      <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
    end else begin
      done        <= 1'b0;
      rdata_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= S_ACTIVE;
            cmd_ready <= 1'b0;
            we_q      <= cmd_we;
            len_q     <= cmd_len;
            next_adr  <= cmd_addr;
            issued    <= '0;
            acked     <= '0;
            outst     <= '0;
            tmo       <= '0;
            wb_cyc_o  <= 1'b1;
            wb_we_o   <= cmd_we;
          end
        end
        S_ACTIVE: begin
          if (abort || last_ack) begin
            state    <= S_FINISH;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            outst    <= '0;
            done     <= 1'b1;
            status   <= err_hit ? 2'b01 : (tmo_hit ? 2'b10 : 2'b00);
            if (last_ack && !we_q) begin
              rdata       <= wb_dat_i;
              rdata_valid <= 1'b1;
            end
          end else begin
            outst <= outst_next;
            if (ack_hit) begin
              acked <= acked + CW'(1);
              tmo   <= '0;
              if (!we_q) begin
                rdata       <= wb_dat_i;
                rdata_valid <= 1'b1;
              end
            end else if (pending) begin
              tmo <= tmo + TW'(1);
            end
            if (can_issue) begin
              wb_stb_o <= 1'b1;
              wb_adr_o <= next_adr;
              next_adr <= next_adr + AW'(SW);
              issued   <= issued + CW'(1);
              if (we_q) wb_dat_o <= wdata;
            end else if (slot_open) begin
              wb_stb_o <= 1'b0;
            end
          end
        end
        S_FINISH: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: a pipelined slave model with
// configurable latency, stall, error and no-ack behaviour.
module tb_wb_burst_master;
  localparam int unsigned AW = 32, DW = 32, LEN_W = 8, MAX_OUTST = 4, TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [DW-1:0] wdata = '0;
  logic wdata_valid = 1'b0, wdata_ready;
  logic [DW-1:0] rdata;
  logic rdata_valid, done;
  logic [1:0] status;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_stall_i = 1'b0;

  always #5 clk = ~clk;

  wb_burst_master #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .MAX_OUTST(MAX_OUTST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .status(status),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
  );

  int unsigned n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // slave model: drives at negedge for the following posedge
  int ack_lat = 0, stall_beat = -1, stall_left = 0, err_beat = -1;
  bit never_ack = 1'b0;
  logic [31:0] slv_adr[$];
  int slv_due[$];
  int slv_acc = 0, slv_resp = 0, cyc_n = 0;

  always @(negedge clk) begin
    cyc_n++;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (slv_adr.size() > 0 && !never_ack && slv_due[0] <= cyc_n) begin
      if (slv_resp == err_beat) wb_err_i = 1'b1;
      else wb_ack_i = 1'b1;
      wb_dat_i = rd_pat(slv_adr[0]);
      void'(slv_adr.pop_front());
      void'(slv_due.pop_front());
      slv_resp++;
    end
    wb_stall_i = 1'b0;
    if (wb_stb_o && slv_acc == stall_beat && stall_left > 0) begin
      wb_stall_i = 1'b1;
      stall_left--;
    end
    if (wb_stb_o && !wb_stall_i) begin
      slv_adr.push_back(wb_adr_o);
      slv_due.push_back(cyc_n + 1 + ack_lat);
      slv_acc++;
    end
  end

  // write-data source, optionally with a valid gap every third cycle
  logic [31:0] wr_words[$];
  int wr_ptr = 0, feed_n = 0;
  bit wr_active = 1'b0, wr_gaps = 1'b0;

  always @(negedge clk) begin
    feed_n++;
    if (wr_active && wr_ptr < wr_words.size() && !(wr_gaps && (feed_n % 3 == 0))) begin
      wdata_valid = 1'b1;
      wdata = wr_words[wr_ptr];
    end else begin
      wdata_valid = 1'b0;
    end
  end

  typedef struct {logic [31:0] adr; logic [31:0] dat;} wbeat_t;
  wbeat_t exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_base = '0, rd_base = '0;
  int rd_idx = 0, acc_n = 0, acc_before_ack = 0, acks_n = 0, outst_m = 0, outst_max = 0;
  int rd_n = 0, done_n = 0, stall_n = 0, wrdy_after_done = 0, gap_n = 0;
  int done_edge = -1, acc_edge_first = -1, err_edge = -1;
  logic [1:0] done_status = '0;
  bit prev_stall = 1'b0, prev_gap = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_adr = '0, prev_dat = '0;

  always @(negedge clk) begin : mon
    wbeat_t e;
    logic [31:0] ea;
    #2;
    if (rst_n) begin
      if ((wb_ack_i || wb_err_i) && outst_m > 0) begin
        if (wb_err_i && err_edge < 0) err_edge = cyc_n;
        acks_n++;
        outst_m--;
      end
      if (prev_stall && wb_cyc_o) begin
        check_eq("stall_stb", 64'(wb_stb_o), 1);
        check_eq("stall_adr", 64'(wb_adr_o), 64'(prev_adr));
        check_eq("stall_dat", 64'(wb_dat_o), 64'(prev_dat));
        check_eq("stall_we", 64'(wb_we_o), 64'(prev_we));
      end
      if (prev_gap) check_eq("gap_stb", 64'(wb_stb_o), 0);
      if (wb_cyc_o && wb_we_o && !wdata_valid && wr_active && wr_ptr < wr_words.size()) gap_n++;
      if (done_n > 0 && wdata_ready) wrdy_after_done++;
      if (wb_stb_o && wb_stall_i) stall_n++;
      if (wdata_valid && wdata_ready) begin
        e.adr = wr_base + 32'(4 * wr_ptr);
        e.dat = wdata;
        exp_wr.push_back(e);
        wr_ptr++;
      end
      if (wb_stb_o && !wb_stall_i) begin
        if (acc_n == 0) acc_edge_first = cyc_n;
        if (acks_n == 0) acc_before_ack++;
        if (wb_we_o) begin
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            check_eq("wr_adr", 64'(wb_adr_o), 64'(e.adr));
            check_eq("wr_dat", 64'(wb_dat_o), 64'(e.dat));
          end else begin
            check_eq("wr_beat_avail", 64'(exp_wr.size()), 1);
          end
        end else begin
          ea = rd_base + 32'(4 * rd_idx);
          check_eq("rd_adr", 64'(wb_adr_o), 64'(ea));
          rd_idx++;
        end
        acc_n++;
        outst_m++;
        if (outst_m > outst_max) outst_max = outst_m;
      end
      if (rdata_valid) begin
        rd_n++;
        if (exp_rd.size() > 0) begin
          ea = exp_rd.pop_front();
          check_eq("rdata", 64'(rdata), 64'(ea));
        end else begin
          check_eq("rdata_unexpected", 64'(rdata_valid), 0);
        end
      end
      if (done) begin
        done_n++;
        done_status = status;
        done_edge = cyc_n - 1;
        outst_m = 0;
        check_eq("done_bus_idle", 64'({wb_cyc_o, wb_stb_o}), 0);
      end
      prev_stall = wb_stb_o && wb_stall_i;
      prev_adr = wb_adr_o;
      prev_dat = wb_dat_o;
      prev_we = wb_we_o;
      prev_gap = wb_cyc_o && wb_we_o && !wdata_valid && (!wb_stb_o || !wb_stall_i);
    end else begin
      prev_stall = 1'b0;
      prev_gap = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic setup();
    exp_wr.delete(); exp_rd.delete(); slv_adr.delete(); slv_due.delete(); wr_words.delete();
    slv_acc = 0; slv_resp = 0; stall_beat = -1; stall_left = 0; err_beat = -1;
    never_ack = 1'b0; ack_lat = 0;
    acc_n = 0; acc_before_ack = 0; acks_n = 0; outst_m = 0; outst_max = 0; rd_n = 0;
    done_n = 0; stall_n = 0; wrdy_after_done = 0; gap_n = 0;
    err_edge = -1; acc_edge_first = -1; done_edge = -1;
    wr_ptr = 0; wr_active = 1'b0; wr_gaps = 1'b0; rd_idx = 0;
  endtask

  task automatic load_words(input int n, input logic [31:0] seed);
    for (int k = 0; k < n; k++) wr_words.push_back(seed ^ (32'h0101_0101 * 32'(k + 1)));
    wr_active = 1'b1;
  endtask

  task automatic start_cmd(input bit we, input logic [31:0] adr, input logic [7:0] len);
    tick();
    wr_base = adr;
    rd_base = adr;
    if (!we) for (int k = 0; k <= int'(len); k++) exp_rd.push_back(rd_pat(adr + 32'(4 * k)));
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = adr; cmd_len = len;
    check_eq("cmd_ready_idle", 64'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    check_eq("cyc_rise", 64'(wb_cyc_o), 1);
    check_eq("cmd_ready_busy", 64'(cmd_ready), 0);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done_n == 0 && n < limit) begin
      tick();
      n++;
    end
    check_eq({tag, "_done"}, 64'(done_n), 1);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check_eq("rst_cmd_ready", 64'(cmd_ready), 1);
    check_eq("rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 0);
    check_eq("rst_pulses", 64'({done, rdata_valid, wdata_ready}), 0);
    check_eq("rst_status", 64'(status), 0);
    check_eq("sel_ones", 64'(wb_sel_o), 64'hF);
    rst_n = 1'b1;
    tick();

    setup(); load_words(4, 32'hA000_0000);
    start_cmd(1'b1, 32'h100, 8'd3);
    wait_done("wr4", 60);
    check_eq("wr4_status", 64'(done_status), 0);
    check_eq("wr4_beats", 64'(acc_n), 4);
    check_eq("wr4_leftover", 64'(exp_wr.size()), 0);

    setup(); stall_beat = 0; stall_left = 2;
    start_cmd(1'b0, 32'h20, 8'd2);
    wait_done("rd_stall", 60);
    check_eq("rd_stall_status", 64'(done_status), 0);
    check_eq("rd_stall_cycles", 64'(stall_n), 2);
    check_eq("rd_stall_count", 64'(rd_n), 3);

    setup(); ack_lat = 10;
    start_cmd(1'b0, 32'h400, 8'd9);
    wait_done("rd_late", 400);
    check_eq("rd_late_status", 64'(done_status), 0);
    check_eq("rd_late_first4", 64'(acc_before_ack), 64'(MAX_OUTST));
    check_eq("rd_late_outst_max", 64'(outst_max), 64'(MAX_OUTST));
    check_eq("rd_late_count", 64'(rd_n), 10);

    setup(); err_beat = 1; load_words(4, 32'hE000_0000);
    start_cmd(1'b1, 32'h200, 8'd3);
    wait_done("wr_err", 60);
    check_eq("wr_err_status", 64'(done_status), 1);
    check_eq("wr_err_edge", 64'(done_edge), 64'(err_edge));
    repeat (5) tick();
    check_eq("wr_err_no_ready", 64'(wrdy_after_done), 0);
    wr_active = 1'b0;

    setup(); never_ack = 1'b1;
    start_cmd(1'b0, 32'h40, 8'd0);
    wait_done("tmo", 80);
    check_eq("tmo_status", 64'(done_status), 2);
    check_eq("tmo_latency", 64'(done_edge - acc_edge_first), 64'(TIMEOUT));
    check_eq("tmo_no_rdata", 64'(rd_n), 0);

    setup(); wr_gaps = 1'b1; load_words(6, 32'h5500_0000);
    start_cmd(1'b1, 32'h300, 8'd5);
    wait_done("wr_gap", 80);
    check_eq("wr_gap_status", 64'(done_status), 0);
    check_eq("wr_gap_beats", 64'(acc_n), 6);
    check_eq("wr_gap_seen", 64'(gap_n > 0), 1);
    check_eq("wr_gap_leftover", 64'(exp_wr.size()), 0);

    setup(); wr_gaps = 1'b1; load_words(8, 32'h7700_0000);
    start_cmd(1'b1, 32'h380, 8'd7);
    n = 0;
    while (acc_n < 3 && n < 50) begin
      tick();
      n++;
    end
    check_eq("rst_mid_reached", 64'(acc_n >= 3), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_bus", 64'({wb_cyc_o, wb_stb_o}), 0);
    check_eq("rst_async_ready", 64'(cmd_ready), 1);
    wr_active = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_eq("rst_no_done", 64'(done_n), 0);
    check_eq("rst_release_ready", 64'(cmd_ready), 1);
    check_eq("rst_release_cyc", 64'(wb_cyc_o), 0);

    setup(); ack_lat = 1;
    start_cmd(1'b0, 32'hFFFF_FFFC, 8'd1);
    wait_done("rd_wrap", 60);
    check_eq("rd_wrap_status", 64'(done_status), 0);
    check_eq("rd_wrap_count", 64'(rd_n), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule
